// File: rtl/bitwise_issue_ctrl.sv
// rtl/bitwise_issue_ctrl.sv - issue controller for an ALU bitwise unit (optional macro: BITWISE_ISSUE_FLAGS_EN)
module bitwise_issue_ctrl #(
   parameter int WIDTH    = 32,
   parameter int TAG_W    = 4,
   parameter int UNIT_LAT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [WIDTH-1:0] unit_i_1,
   output logic [WIDTH-1:0] unit_i_2,
   output logic             unit_enable,
   input  logic [WIDTH-1:0] unit_o,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
`ifdef BITWISE_ISSUE_FLAGS_EN
   output logic             rsp_zero,
   output logic             rsp_ones,
`endif
   output logic             busy
);

   // Counter must hold UNIT_LAT; a zero-latency unit still gets one bit.
   localparam int CNT_W = (UNIT_LAT > 0) ? $clog2(UNIT_LAT + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [WIDTH-1:0] data_q, data_d;
`ifdef BITWISE_ISSUE_FLAGS_EN
   logic             zero_q, zero_d;
   logic             ones_q, ones_d;
`endif

   logic accept;

   assign req_ready   = (state_q == S_IDLE) & rst_n;
   assign accept      = req_valid & req_ready;
   assign unit_enable = (state_q == S_WAIT);
   assign rsp_valid   = (state_q == S_RESP);
   assign busy        = (state_q != S_IDLE);
   assign unit_i_1    = op_a_q;
   assign unit_i_2    = op_b_q;
   assign rsp_data    = data_q;
   assign rsp_tag     = tag_q;
`ifdef BITWISE_ISSUE_FLAGS_EN
   assign rsp_zero    = zero_q;
   assign rsp_ones    = ones_q;
`endif

   // Next-state: accept in IDLE, count out the unit latency in WAIT, hold the result in RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      tag_d   = tag_q;
      data_d  = data_q;
`ifdef BITWISE_ISSUE_FLAGS_EN
      zero_d  = zero_q;
      ones_d  = ones_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_a_d  = req_a;
               op_b_d  = req_b;
               tag_d   = req_tag;
               cnt_d   = CNT_W'(UNIT_LAT);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               data_d  = unit_o;
`ifdef BITWISE_ISSUE_FLAGS_EN
               zero_d  = (unit_o == '0);
               ones_d  = (unit_o == '1);
`endif
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any request in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         tag_q   <= '0;
         data_q  <= '0;
`ifdef BITWISE_ISSUE_FLAGS_EN
         zero_q  <= 1'b0;
         ones_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
`ifdef BITWISE_ISSUE_FLAGS_EN
         zero_q  <= zero_d;
         ones_q  <= ones_d;
`endif
      end
   end

endmodule

// File: tb/tb_bitwise_issue_ctrl.sv
// tb/tb_bitwise_issue_ctrl.sv - bench for bitwise_issue_ctrl at UNIT_LAT 0 and 3
module tb_bitwise_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid   [2];
   logic        req_ready   [2];
   logic [31:0] req_a       [2];
   logic [31:0] req_b       [2];
   logic [3:0]  req_tag     [2];
   logic [31:0] unit_i_1    [2];
   logic [31:0] unit_i_2    [2];
   logic        unit_enable [2];
   logic [31:0] unit_o      [2];
   logic        rsp_valid   [2];
   logic        rsp_ready   [2];
   logic [31:0] rsp_data    [2];
   logic [3:0]  rsp_tag     [2];
   logic        busy        [2];
`ifdef BITWISE_ISSUE_FLAGS_EN
   logic        rsp_zero    [2];
   logic        rsp_ones    [2];
`endif

   int tests;
   int fails;
   int en_run [2];

   bitwise_issue_ctrl #(.WIDTH(32), .TAG_W(4), .UNIT_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a[0]), .req_b(req_b[0]), .req_tag(req_tag[0]),
      .unit_i_1(unit_i_1[0]), .unit_i_2(unit_i_2[0]),
      .unit_enable(unit_enable[0]), .unit_o(unit_o[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_data(rsp_data[0]), .rsp_tag(rsp_tag[0]),
`ifdef BITWISE_ISSUE_FLAGS_EN
      .rsp_zero(rsp_zero[0]), .rsp_ones(rsp_ones[0]),
`endif
      .busy(busy[0])
   );

   bitwise_issue_ctrl #(.WIDTH(32), .TAG_W(4), .UNIT_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a[1]), .req_b(req_b[1]), .req_tag(req_tag[1]),
      .unit_i_1(unit_i_1[1]), .unit_i_2(unit_i_2[1]),
      .unit_enable(unit_enable[1]), .unit_o(unit_o[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_data(rsp_data[1]), .rsp_tag(rsp_tag[1]),
`ifdef BITWISE_ISSUE_FLAGS_EN
      .rsp_zero(rsp_zero[1]), .rsp_ones(rsp_ones[1]),
`endif
      .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit models: output is garbage until enable has been high for the unit's latency.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_run[0] <= 0;
         en_run[1] <= 0;
      end else begin
         en_run[0] <= unit_enable[0] ? en_run[0] + 1 : 0;
         en_run[1] <= unit_enable[1] ? en_run[1] + 1 : 0;
      end
   end
   assign unit_o[0] = unit_enable[0] ? (unit_i_1[0] & unit_i_2[0]) : 32'hDEAD_BEEF;
   assign unit_o[1] = (unit_enable[1] && en_run[1] >= 3) ? (unit_i_1[1] & unit_i_2[1]) : 32'hDEAD_BEEF;

   function automatic int lat_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // One full transaction on instance d, checked against a & b with the given response stall.
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input int stall);
      int n;
      int en;
      int lat;
      logic [31:0] exp;
      exp = a & b;
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_before_issue", 64'(req_ready[d]), 64'(1));
      req_a[d] = a;
      req_b[d] = b;
      req_tag[d] = tag;
      req_valid[d] = 1'b1;
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      en = 0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         if (rsp_valid[d]) break;
         if (unit_enable[d]) en++;
         lat++;
      end
      chk("latency", 64'(lat), 64'(lat_of(d) + 1));
      chk("enable_cycles", 64'(en), 64'(lat_of(d) + 1));
      chk("enable_low_in_resp", 64'(unit_enable[d]), 64'(0));
      chk("rsp_data", 64'(rsp_data[d]), 64'(exp));
      chk("rsp_tag", 64'(rsp_tag[d]), 64'(tag));
`ifdef BITWISE_ISSUE_FLAGS_EN
      chk("rsp_zero", 64'(rsp_zero[d]), 64'(exp == 32'h0));
      chk("rsp_ones", 64'(rsp_ones[d]), 64'(exp == 32'hFFFF_FFFF));
`endif
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_rsp_valid", 64'(rsp_valid[d]), 64'(1));
         chk("stall_rsp_data", 64'(rsp_data[d]), 64'(exp));
         chk("stall_rsp_tag", 64'(rsp_tag[d]), 64'(tag));
         chk("stall_req_ready", 64'(req_ready[d]), 64'(0));
      end
      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[d] = 1'b0;
      @(negedge clk);
      chk("post_rsp_valid", 64'(rsp_valid[d]), 64'(0));
      chk("post_req_ready", 64'(req_ready[d]), 64'(1));
      chk("post_busy", 64'(busy[d]), 64'(0));
      chk("hold_i_1", 64'(unit_i_1[d]), 64'(a));
      chk("hold_i_2", 64'(unit_i_2[d]), 64'(b));
   endtask

   initial begin
      int seen;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_a[d] = 32'h0;
         req_b[d] = 32'h0;
         req_tag[d] = 4'h0;
         rsp_ready[d] = 1'b0;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 64'(req_ready[d]), 64'(0));
         chk("rst_rsp_valid", 64'(rsp_valid[d]), 64'(0));
         chk("rst_unit_enable", 64'(unit_enable[d]), 64'(0));
         chk("rst_unit_i_1", 64'(unit_i_1[d]), 64'(0));
         chk("rst_busy", 64'(busy[d]), 64'(0));
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_req_ready0", 64'(req_ready[0]), 64'(1));
      chk("release_req_ready1", 64'(req_ready[1]), 64'(1));

      // Directed: reference vector, backpressure, latency-3 unit, flag vectors.
      txn(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd3, 0);
      txn(0, 32'h1357_9BDF, 32'hFFFF_0000, 4'd7, 5);
      txn(1, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd9, 0);
      txn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 2);
      txn(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 0);
      txn(0, 32'hAAAA_AAAA, 32'h5555_5555, 4'd5, 1);

      // Reset pulse during WAIT abandons the request.
      req_a[1] = 32'h1234_5678;
      req_b[1] = 32'hFFFF_FFFF;
      req_tag[1] = 4'hA;
      req_valid[1] = 1'b1;
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(negedge clk);
      chk("wait_enable", 64'(unit_enable[1]), 64'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_enable", 64'(unit_enable[1]), 64'(0));
      chk("midrst_busy", 64'(busy[1]), 64'(0));
      chk("midrst_i_1", 64'(unit_i_1[1]), 64'(0));
      chk("midrst_req_ready", 64'(req_ready[1]), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid[1]) seen++;
      end
      chk("abandoned_no_rsp", 64'(seen), 64'(0));
      txn(1, 32'hCAFE_F00D, 32'h0F0F_0F0F, 4'hB, 0);

      // Randomized traffic on both instances.
      for (int k = 0; k < 16; k++) begin
         txn(k % 2, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
